// File: rtl/spectro_pkg.sv
// Shared types and default geometry for the spectrum capture path.
package spectro_pkg;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_FRAME_LEN = 256;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        DONE
    } state_t;
endpackage

// File: rtl/spectrum_peak_tracker.sv
// Running maximum of written bins with first-occurrence index; 1-cycle registered update.
// No flow control: follows the writer's write strobe.
module spectrum_peak_tracker
    import spectro_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              upd,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] bin,
    output logic [DATA_W-1:0] peak_mag,
    output logic [ADDR_W-1:0] peak_bin
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            peak_mag <= '0;
            peak_bin <= '0;
        end else if (upd && (data > peak_mag)) begin
            // Strict compare keeps the earliest bin on ties.
            peak_mag <= data;
            peak_bin <= bin;
        end
    end

endmodule

// File: rtl/spectrum_frame_writer.sv
// Frame-aligned capture of one spectrum into the SRAM W0 port; writes appear 1 cycle after acceptance.
// in_ready drops outside WAIT_SOF/CAPTURE; optional peak tracking under SPECTRUM_PEAK_TRACK_EN.
module spectrum_frame_writer
    import spectro_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              ack_i,
    input  logic              continuous_i,
    output logic              W0_clk,
    output logic              W0_en,
    output logic [ADDR_W-1:0] W0_addr,
    output logic [DATA_W-1:0] W0_data,
    output logic              busy_o,
    output logic              done_irq,
    output logic              short_err,
    output logic              long_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [DATA_W-1:0] peak_mag,
    output logic [ADDR_W-1:0] peak_bin
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic              beat_acc;
    logic              cap_beat;
    logic              last_slot;
    logic              enter_capture;
    logic              enter_done;
    logic              arming;

    assign W0_clk    = wb_clk_i;
    assign in_ready  = (state == WAIT_SOF) || (state == CAPTURE);
    assign busy_o    = in_ready;
    assign beat_acc  = in_valid && in_ready;
    assign cap_beat  = beat_acc && (state == CAPTURE);
    assign last_slot = (addr == LAST_ADDR);

    always_comb begin
        state_next = state;
        if (abort_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (arm_i) state_next = WAIT_SOF;
                WAIT_SOF: if (beat_acc && in_last) state_next = CAPTURE;
                CAPTURE:  if (cap_beat && (in_last || last_slot)) state_next = DONE;
                DONE:     if (ack_i) state_next = continuous_i ? WAIT_SOF : IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    assign enter_capture = (state == WAIT_SOF) && (state_next == CAPTURE);
    assign enter_done    = (state == CAPTURE) && (state_next == DONE);
    assign arming        = (state == IDLE) && (state_next == WAIT_SOF);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            addr      <= '0;
            W0_en     <= 1'b0;
            W0_addr   <= '0;
            W0_data   <= '0;
            done_irq  <= 1'b0;
            short_err <= 1'b0;
            long_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state    <= state_next;
            // A beat taken in an abort cycle is still committed to SRAM.
            W0_en    <= cap_beat;
            done_irq <= (state_next == DONE);
            if (cap_beat) begin
                W0_addr <= addr;
                W0_data <= in_data;
                addr    <= addr + ADDR_W'(1);
            end
            if (enter_capture) addr <= '0;
            if (arming) begin
                short_err <= 1'b0;
                long_err  <= 1'b0;
            end
            if (enter_done) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                if (in_last && !last_slot) short_err <= 1'b1;
                if (!in_last && last_slot) long_err  <= 1'b1;
            end
        end
    end

`ifdef SPECTRUM_PEAK_TRACK_EN
    spectrum_peak_tracker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_peak (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clr      (enter_capture),
        .upd      (cap_beat),
        .data     (in_data),
        .bin      (addr),
        .peak_mag (peak_mag),
        .peak_bin (peak_bin)
    );
`else
    assign peak_mag = '0;
    assign peak_bin = '0;
`endif

endmodule

// File: tb/tb_spectrum_frame_writer.sv
// Scoreboard bench: stimulus pushes expected SRAM writes, a negedge monitor pops and compares.
module tb_spectrum_frame_writer;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 256;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_last;
    logic [DATA_W-1:0] in_data;
    logic              arm_i, abort_i, ack_i, continuous_i;
    logic              W0_clk, W0_en;
    logic [ADDR_W-1:0] W0_addr;
    logic [DATA_W-1:0] W0_data;
    logic              busy_o, done_irq, short_err, long_err;
    logic [CNT_W-1:0]  frame_cnt;
    logic [DATA_W-1:0] peak_mag;
    logic [ADDR_W-1:0] peak_bin;

    always #5 clk = ~clk;

    spectrum_frame_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .arm_i(arm_i), .abort_i(abort_i), .ack_i(ack_i), .continuous_i(continuous_i),
        .W0_clk(W0_clk), .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
        .busy_o(busy_o), .done_irq(done_irq), .short_err(short_err), .long_err(long_err),
        .frame_cnt(frame_cnt), .peak_mag(peak_mag), .peak_bin(peak_bin)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic        exp_short = 1'b0;
    logic        exp_long  = 1'b0;
    logic [31:0] exp_pk;
    int          exp_pb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every SRAM write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (W0_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected", W0_addr, W0_data);
            end else begin
                e = exp_q.pop_front();
                if (W0_addr !== ADDR_W'(e.addr) || W0_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                             W0_addr, W0_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat offer, with an occasional idle gap; acc reports whether it was taken.
    task automatic beat(input logic [31:0] d, input logic l, output logic acc);
        if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        acc = in_ready;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic arm();
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        exp_short = 1'b0;
        exp_long  = 1'b0;
    endtask

    task automatic ack();
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
    endtask

    task automatic sof(input int junk);
        logic acc;
        for (int j = 0; j < junk; j++) begin
            beat($urandom, j == junk - 1, acc);
            check("sof_ready", acc, 1);
        end
    endtask

    // Reference: bins 0..min(n, FRAME_LEN, last+1)-1 are written in order; peak is first strict max.
    task automatic stream(input int n, input int last_idx, input int mode);
        logic        acc;
        logic [31:0] d;
        int          exp_wr, cnt;
        wr_t         w;
        exp_wr = (n < FRAME_LEN) ? n : FRAME_LEN;
        if (last_idx >= 0 && last_idx + 1 < exp_wr) exp_wr = last_idx + 1;
        exp_pk = 0;
        exp_pb = 0;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       d = i;
                1:       d = $urandom;
                default: d = (i == 7 || i == 20) ? 32'd5 : 32'($urandom_range(4));
            endcase
            if (i < exp_wr) begin
                w.addr = i;
                w.data = d;
                exp_q.push_back(w);
                if (d > exp_pk) begin
                    exp_pk = d;
                    exp_pb = i;
                end
            end
            beat(d, i == last_idx, acc);
            if (acc) cnt++;
            else break;
        end
        check("accepted_beats", cnt, exp_wr);
    endtask

    task automatic run_frame(input int junk, input int n, input int last_idx, input int mode);
        sof(junk);
        stream(n, last_idx, mode);
        exp_cnt++;
        if (last_idx >= 0 && last_idx < FRAME_LEN - 1) exp_short = 1'b1;
        if (!(last_idx >= 0 && last_idx <= FRAME_LEN - 1)) exp_long = 1'b1;
        check("done_irq", done_irq, 1);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("short_err", short_err, exp_short);
        check("long_err", long_err, exp_long);
        check("ready_in_done", in_ready, 0);
`ifdef SPECTRUM_PEAK_TRACK_EN
        check("peak_mag", peak_mag, exp_pk);
        check("peak_bin", peak_bin, exp_pb);
`else
        check("peak_mag", peak_mag, 0);
        check("peak_bin", peak_bin, 0);
`endif
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 0);
        check("rst_W0_en", W0_en, 0);
        check("rst_W0_addr", W0_addr, 0);
        check("rst_W0_data", W0_data, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done_irq", done_irq, 0);
        check("rst_short_err", short_err, 0);
        check("rst_long_err", long_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_peak_bin", peak_bin, 0);
    endtask

    initial begin
        logic        acc;
        logic [31:0] d;
        wr_t         w;
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        arm_i = 1'b0; abort_i = 1'b0; ack_i = 1'b0; continuous_i = 1'b0;
        repeat (3) step();
        check_reset_values();
        rst = 1'b0;
        step();

        // Full frame after 10 junk beats, data equals bin index.
        arm();
        check("armed_busy", busy_o, 1);
        check("armed_ready", in_ready, 1);
        run_frame(10, FRAME_LEN, FRAME_LEN - 1, 0);
        ack();
        check("ack_done_irq", done_irq, 0);
        check("ack_idle_ready", in_ready, 0);
        check("ack_idle_busy", busy_o, 0);

        // Short frame, then re-arm clears the sticky error.
        arm();
        run_frame(3, 100, 99, 1);
        ack();
        arm();
        check("rearm_short_clr", short_err, 0);
        check("rearm_busy", busy_o, 1);

        // No last: exactly FRAME_LEN writes, beat FRAME_LEN+1 refused.
        run_frame(1, FRAME_LEN + 1, -1, 1);

        // Continuous re-arm on ack.
        continuous_i = 1'b1;
        ack();
        check("cont_ready", in_ready, 1);
        check("cont_done_irq", done_irq, 0);
        run_frame(2, FRAME_LEN, FRAME_LEN - 1, 1);
        continuous_i = 1'b0;
        ack();
        check("noncont_ready", in_ready, 0);

        // Tied peak values: first occurrence wins.
        arm();
        run_frame(1, FRAME_LEN, FRAME_LEN - 1, 2);
        ack();

        // Abort with simultaneous arm at beat 50; that beat is still written.
        arm();
        sof(1);
        stream(50, -1, 1);
        d = $urandom;
        w.addr = 50;
        w.data = d;
        exp_q.push_back(w);
        in_valid = 1'b1; in_data = d; in_last = 1'b0;
        abort_i = 1'b1; arm_i = 1'b1;
        step();
        abort_i = 1'b0; arm_i = 1'b0;
        check("abort_ready", in_ready, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done_irq", done_irq, 0);
        for (int k = 0; k < 5; k++) begin
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        check("abort_frame_cnt", frame_cnt, exp_cnt);

        // Abort while holding a finished frame drops done_irq.
        arm();
        run_frame(1, 2, 1, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("abort_done_irq2", done_irq, 0);
        check("abort_idle_ready", in_ready, 0);

        // Synchronous reset mid-frame.
        arm();
        sof(1);
        stream(30, -1, 1);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = $urandom;
        step();
        check_reset_values();
        exp_cnt = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) step();
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spectrum_frame_writer.md
Name: spectrum_frame_writer

Overview:
Capture stage directly upstream of the 32x256 spectrum SRAM. Accepts a valid/ready stream of 32-bit magnitude bins from the FFT/magnitude chain, aligns to frame boundaries, and writes exactly one frame into SRAM through the W0 write port (W0_addr/W0_en/W0_clk/W0_data). Signals frame-complete to the Wishbone readout side and waits for an acknowledge before overwriting, so the reader sees a stable frame.

Parameters:
ADDR_W, 8, SRAM address width
DATA_W, 32, sample/SRAM word width
FRAME_LEN, 256, bins per frame; 2 <= FRAME_LEN <= 2**ADDR_W
CNT_W, 16, width of completed-frame counter

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous active-high reset
in_valid  in  1  stream beat valid
in_ready  out  1  stream beat ready
in_data  in  DATA_W  magnitude bin
in_last  in  1  last bin of FFT frame
arm_i  in  1  pulse: start capture
abort_i  in  1  pulse: abandon capture, return to IDLE
ack_i  in  1  pulse: reader finished with SRAM contents
continuous_i  in  1  level: re-arm automatically after ack
W0_clk  out  1  SRAM write clock (= wb_clk_i)
W0_en  out  1  SRAM write enable, active high
W0_addr  out  ADDR_W  SRAM write address
W0_data  out  DATA_W  SRAM write data
busy_o  out  1  state is WAIT_SOF or CAPTURE
done_irq  out  1  level: frame in SRAM, awaiting ack
short_err  out  1  sticky: in_last before FRAME_LEN bins
long_err  out  1  sticky: FRAME_LEN bins without in_last
frame_cnt  out  CNT_W  completed frames
peak_mag  out  DATA_W  see Optional Feature
peak_bin  out  ADDR_W  see Optional Feature

Behaviour:
- Clock and reset: one clock, wb_clk_i; wb_rst_i is synchronous, active-high.
- Reset values: state IDLE; in_ready, W0_en, busy_o, done_irq, short_err, long_err = 0; W0_addr, W0_data, frame_cnt, peak_mag, peak_bin = 0.
- Beat accepted when in_valid && in_ready.
- in_ready is 1 in WAIT_SOF and CAPTURE, and 0 in IDLE and DONE (upstream stalls).
- IDLE:
  - arm_i -> WAIT_SOF.
  - Clears short_err and long_err on the same edge.
- WAIT_SOF:
  - Accepted beats are dropped (never written).
  - An accepted beat with in_last=1 -> CAPTURE, write address reset to 0.
- CAPTURE:
  - Each accepted beat produces W0_en=1, W0_addr=addr, W0_data=in_data on the next cycle; latency 1 and registered; addr increments.
  - in_last at addr==FRAME_LEN-1 -> DONE, normal completion.
  - in_last at addr<FRAME_LEN-1 -> beat written, short_err=1, -> DONE.
  - Beat at addr==FRAME_LEN-1 with in_last=0 -> beat written, long_err=1, -> DONE.
- W0_en is high only in the cycle after an accepted CAPTURE beat; otherwise 0. W0_addr and W0_data hold their last values.
- Entry to DONE:
  - frame_cnt increments, wrapping 2**CNT_W-1 -> 0.
  - done_irq=1 from the first cycle in DONE.
- DONE:
  - ack_i -> done_irq=0 next cycle.
  - Next state is WAIT_SOF if continuous_i=1, else IDLE.
  - arm_i is ignored.
- abort_i in any state -> IDLE next cycle, done_irq=0. A beat accepted in the abort cycle is still written (the write is already registered); no further writes.
- Simultaneous events:
  - abort_i beats arm_i and ack_i.
  - arm_i while not in IDLE is ignored.
- Reset mid-capture: writes stop at the next edge; SRAM contents are undefined to the reader and frame_cnt is cleared.
- W0_clk is a direct assign of wb_clk_i.

Optional Feature:
Macro SPECTRUM_PEAK_TRACK_EN.
- Defined:
  - peak_mag and peak_bin are cleared on entry to CAPTURE.
  - On each written beat, if in_data > peak_mag (unsigned, strict), the block updates peak_mag=in_data and peak_bin=addr. On ties the first occurrence wins.
  - Values are valid and held from DONE entry until the next CAPTURE entry.
- Undefined: peak_mag and peak_bin are tied to 0; no tracking logic.

Decomposition:
- Package spectro_pkg:
  - state enum {IDLE, WAIT_SOF, CAPTURE, DONE}.
  - Default ADDR_W, DATA_W, FRAME_LEN and CNT_W constants.
- Sub-module spectrum_peak_tracker (compare/update for peak_mag and peak_bin), instantiated only under SPECTRUM_PEAK_TRACK_EN.

Test Plan:
- Arm, stream 10 junk beats then last, then 256 beats data=i with last on i=255 -> 256 writes addr 0..255 with data 0..255; done_irq=1; frame_cnt=1; errors 0.
- In CAPTURE, last at beat 99 -> 100 writes; short_err=1; DONE. Next arm_i -> short_err=0.
- 256 beats with no last -> 256 writes; long_err=1; beat 257 sees in_ready=0.
- continuous_i=1, ack_i in DONE -> WAIT_SOF next cycle, second frame captured, frame_cnt=2. With continuous_i=0 -> IDLE, in_ready=0.
- abort_i and arm_i in the same cycle at beat 50 -> IDLE, no W0_en after the cycle following abort, done_irq=0. Reset asserted mid-frame -> all outputs at reset values next edge.
- SPECTRUM_PEAK_TRACK_EN, data 5 at bins 7 and 20, max elsewhere 4 -> peak_mag=5, peak_bin=7.
